abus_arbiter_lock: RTL and testbench

ABUS_ARBITER_LOCK -- requirements
Module: abus_arbiter_lock

---
 rtl/abus_pkg.sv | 41 ++++
 rtl/abus_sched.sv | 17 +
 rtl/abus_arbiter_lock.sv | 184 ++++++++++++++++++
 tb/tb_abus_arbiter_lock.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/abus_pkg.sv
// Shared ABUS arbiter definitions: FSM encoding, strobe width formula,
// scheduler pick function and slave one-hot decoder.
package abus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_ERR  = 2'd2
   } abus_state_e;

   localparam int MAX_MASTER = 8;
   localparam int MAX_SLAVE  = 8;

   function automatic int strb_width(input int data_width);
      return $clog2(data_width + 1);
   endfunction

   // Walks the requesters starting at the pointer (or at 0), wrapping at nb.
   function automatic logic [MAX_MASTER-1:0] pick_grant(
      input logic [MAX_MASTER-1:0] req,
      input logic [2:0]            ptr,
      input logic                  lowest_first,
      input int                    nb
   );
      logic [MAX_MASTER-1:0] gnt;
      int start;
      int idx;
      gnt   = '0;
      start = lowest_first ? 0 : int'(ptr);
      for (int i = 0; i < MAX_MASTER; i++) begin
         idx = (start + i) % nb;
         if (i < nb && gnt == '0 && req[idx[2:0]]) gnt[idx[2:0]] = 1'b1;
      end
      return gnt;
   endfunction

   function automatic logic [MAX_SLAVE-1:0] decode_slave(input logic [2:0] idx);
      return MAX_SLAVE'(1) << idx;
   endfunction

endpackage

// File: rtl/abus_sched.sv
// ABUS scheduler: turns the request vector into a one-hot grant, either
// round robin from the priority pointer or lowest index first.
module abus_sched
   import abus_pkg::*;
#(
   parameter int NB_MASTER = 2,
   parameter int PW        = 1
) (
   input  logic [NB_MASTER-1:0] req,
   input  logic [PW-1:0]        ptr,
   input  logic                 mode,
   output logic [NB_MASTER-1:0] grant
);

   assign grant = NB_MASTER'(pick_grant(MAX_MASTER'(req), 3'(ptr), mode, NB_MASTER));

endmodule

// File: rtl/abus_arbiter_lock.sv
// ABUS arbiter with a locked grant: one master at a time is forwarded to the
// addressed slave until the slave acks, the master aborts, or the timeout fires.
module abus_arbiter_lock
   import abus_pkg::*;
#(
   parameter int  NB_MASTER  = 2,
   parameter int  NB_SLAVE   = 2,
   parameter int  ADDR_WIDTH = 16,
   parameter int  DATA_WIDTH = 16,
   parameter int  SCHEDULER  = 0,
   parameter int  TIMEOUT    = 15,
   localparam int SW         = strb_width(DATA_WIDTH)
) (
   input  logic                             abus_clk,
   input  logic                             abus_rst,
   input  logic [3*NB_MASTER-1:0]           abus_mid,
   input  logic [NB_MASTER-1:0]             abus_mreq,
   input  logic [NB_MASTER-1:0]             abus_mwrite,
   input  logic [NB_MASTER-1:0]             abus_mread,
   input  logic [NB_MASTER-1:0]             abus_mabort,
   input  logic [NB_MASTER*SW-1:0]          abus_mstrb,
   input  logic [NB_MASTER*SW-1:0]          abus_mkeep,
   input  logic [NB_MASTER*DATA_WIDTH-1:0]  abus_mwdata,
   input  logic [NB_MASTER*ADDR_WIDTH-1:0]  abus_maddress,
   output logic [NB_MASTER-1:0]             abus_mgrant,
   output logic [NB_MASTER-1:0]             abus_mack,
   output logic                             abus_merr,
   output logic [DATA_WIDTH-1:0]            abus_mrdata,
   input  logic [NB_SLAVE-1:0]              abus_sack,
   input  logic [NB_SLAVE*DATA_WIDTH-1:0]   abus_srdata,
   output logic [NB_SLAVE-1:0]              abus_ssel,
   output logic [2:0]                       abus_smid,
   output logic                             abus_sreq,
   output logic                             abus_swrite,
   output logic                             abus_sread,
   output logic                             abus_sabort,
   output logic [SW-1:0]                    abus_sstrb,
   output logic [SW-1:0]                    abus_skeep,
   output logic [ADDR_WIDTH-1:0]            abus_saddress,
   output logic [DATA_WIDTH-1:0]            abus_swdata
);

   localparam int   PW           = $clog2(NB_MASTER);
   localparam int   SLW          = (NB_SLAVE > 1) ? $clog2(NB_SLAVE) : 1;
   localparam int   CW           = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic LOWEST_FIRST = (SCHEDULER != 0);
   localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

   abus_state_e          state_q, state_d;
   logic [NB_MASTER-1:0] grant_q, grant_d, sched_grant;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [PW-1:0]        ptr_q, ptr_d, ptr_exit;
   logic                 has_grant, sack_sel, abort_cond;
   int                   gsel, sidx;

   abus_sched #(
      .NB_MASTER (NB_MASTER),
      .PW        (PW)
   ) u_sched (
      .req   (abus_mreq),
      .ptr   (ptr_q),
      .mode  (LOWEST_FIRST),
      .grant (sched_grant)
   );

   always_comb begin
      gsel = 0;
      for (int i = 0; i < NB_MASTER; i++) begin
         if (grant_q[i]) gsel = i;
      end
   end

   assign has_grant   = |grant_q;
   assign abus_mgrant = grant_q;
   assign abort_cond  = abus_mabort[gsel] || !abus_mreq[gsel];
   assign ptr_exit    = LOWEST_FIRST ? ptr_q :
                        (gsel == NB_MASTER - 1) ? '0 : PW'(gsel + 1);

   // The slave-side command is a plain mux of the locked master; nothing leaks when ungranted.
   always_comb begin
      abus_smid     = '0;
      abus_sreq     = 1'b0;
      abus_swrite   = 1'b0;
      abus_sread    = 1'b0;
      abus_sabort   = 1'b0;
      abus_sstrb    = '0;
      abus_skeep    = '0;
      abus_saddress = '0;
      abus_swdata   = '0;
      if (has_grant) begin
         abus_smid     = abus_mid[gsel*3 +: 3];
         abus_sreq     = abus_mreq[gsel];
         abus_swrite   = abus_mwrite[gsel];
         abus_sread    = abus_mread[gsel];
         abus_sstrb    = abus_mstrb[gsel*SW +: SW];
         abus_skeep    = abus_mkeep[gsel*SW +: SW];
         abus_saddress = abus_maddress[gsel*ADDR_WIDTH +: ADDR_WIDTH];
         abus_swdata   = abus_mwdata[gsel*DATA_WIDTH +: DATA_WIDTH];
         abus_sabort   = abus_mabort[gsel] || state_q == ST_ERR ||
                         (state_q == ST_BUSY && !abus_mreq[gsel]);
      end
   end

   generate
      if (NB_SLAVE > 1) begin : g_multi_slave
         assign sidx = int'(abus_saddress[ADDR_WIDTH-1 -: SLW]);
      end else begin : g_single_slave
         assign sidx = 0;
      end
   endgenerate

   always_comb begin
      abus_ssel   = '0;
      abus_mrdata = '0;
      if (state_q == ST_BUSY && has_grant) begin
         abus_ssel   = NB_SLAVE'(decode_slave(3'(sidx)));
         abus_mrdata = abus_srdata[sidx*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   assign sack_sel = |(abus_sack & abus_ssel);

   // Abort outranks ack; ack outranks the timeout on the same cycle.
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      cnt_d     = cnt_q;
      ptr_d     = ptr_q;
      abus_mack = '0;
      abus_merr = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (|abus_mreq) begin
               grant_d = sched_grant;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (abort_cond) begin
               grant_d = '0;
               state_d = ST_IDLE;
               ptr_d   = ptr_exit;
            end else if (sack_sel) begin
               abus_mack = grant_q;
               grant_d   = '0;
               state_d   = ST_IDLE;
               ptr_d     = ptr_exit;
            end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
               state_d = ST_ERR;
               ptr_d   = ptr_exit;
            end else if (TIMEOUT != 0) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_ERR: begin
            abus_mack = grant_q;
            abus_merr = 1'b1;
            grant_d   = '0;
            cnt_d     = '0;
            state_d   = ST_IDLE;
         end
         default: begin
            grant_d = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge abus_clk) begin
      if (abus_rst) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         cnt_q   <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
      end
   end

endmodule

// File: tb/tb_abus_arbiter_lock.sv
// Bench for abus_arbiter_lock: directed protocol scenarios plus randomized
// transactions checked against a transaction-level arbitration model.
module tb_abus_arbiter_lock;

   localparam int NBM = 3;
   localparam int NBS = 2;
   localparam int AW  = 16;
   localparam int DW  = 16;
   localparam int SW  = 5;
   localparam int TO  = 4;

   localparam int K_ACK     = 0;
   localparam int K_ABORT   = 1;
   localparam int K_DROP    = 2;
   localparam int K_TIMEOUT = 3;

   logic                abus_clk = 1'b0;
   logic                abus_rst;
   logic [3*NBM-1:0]    mid;
   logic [NBM-1:0]      mreq, mwrite, mread, mabort;
   logic [NBM*SW-1:0]   mstrb, mkeep;
   logic [NBM*DW-1:0]   mwdata;
   logic [NBM*AW-1:0]   maddr;
   logic [NBS-1:0]      sack;
   logic [NBS*DW-1:0]   srdata;

   logic [NBM-1:0]      mgrant, mack;
   logic                merr, sreq, swrite, sread, sabort;
   logic [DW-1:0]       mrdata, swdata;
   logic [NBS-1:0]      ssel;
   logic [2:0]          smid;
   logic [SW-1:0]       sstrb, skeep;
   logic [AW-1:0]       saddr;

   logic [NBM-1:0]      lf_mgrant, lf_mack;
   logic                lf_merr, lf_sreq, lf_swrite, lf_sread, lf_sabort;
   logic [DW-1:0]       lf_mrdata, lf_swdata;
   logic [NBS-1:0]      lf_ssel;
   logic [2:0]          lf_smid;
   logic [SW-1:0]       lf_sstrb, lf_skeep;
   logic [AW-1:0]       lf_saddr;

   int pass_cnt  = 0;
   int total_cnt = 0;

   logic [NBM-1:0] pending;
   int             rr_ptr;

   always #5 abus_clk = ~abus_clk;

   abus_arbiter_lock #(
      .NB_MASTER(NBM), .NB_SLAVE(NBS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
      .SCHEDULER(0), .TIMEOUT(TO)
   ) dut_rr (
      .abus_clk(abus_clk), .abus_rst(abus_rst), .abus_mid(mid), .abus_mreq(mreq),
      .abus_mwrite(mwrite), .abus_mread(mread), .abus_mabort(mabort),
      .abus_mstrb(mstrb), .abus_mkeep(mkeep), .abus_mwdata(mwdata),
      .abus_maddress(maddr), .abus_mgrant(mgrant), .abus_mack(mack),
      .abus_merr(merr), .abus_mrdata(mrdata), .abus_sack(sack),
      .abus_srdata(srdata), .abus_ssel(ssel), .abus_smid(smid),
      .abus_sreq(sreq), .abus_swrite(swrite), .abus_sread(sread),
      .abus_sabort(sabort), .abus_sstrb(sstrb), .abus_skeep(skeep),
      .abus_saddress(saddr), .abus_swdata(swdata)
   );

   abus_arbiter_lock #(
      .NB_MASTER(NBM), .NB_SLAVE(NBS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
      .SCHEDULER(1), .TIMEOUT(TO)
   ) dut_lf (
      .abus_clk(abus_clk), .abus_rst(abus_rst), .abus_mid(mid), .abus_mreq(mreq),
      .abus_mwrite(mwrite), .abus_mread(mread), .abus_mabort(mabort),
      .abus_mstrb(mstrb), .abus_mkeep(mkeep), .abus_mwdata(mwdata),
      .abus_maddress(maddr), .abus_mgrant(lf_mgrant), .abus_mack(lf_mack),
      .abus_merr(lf_merr), .abus_mrdata(lf_mrdata), .abus_sack(sack),
      .abus_srdata(srdata), .abus_ssel(lf_ssel), .abus_smid(lf_smid),
      .abus_sreq(lf_sreq), .abus_swrite(lf_swrite), .abus_sread(lf_sread),
      .abus_sabort(lf_sabort), .abus_sstrb(lf_sstrb), .abus_skeep(lf_skeep),
      .abus_saddress(lf_saddr), .abus_swdata(lf_swdata)
   );

   // Round robin rule: first requester found scanning upward from the pointer.
   function automatic int model_winner(input logic [NBM-1:0] req, input int ptr);
      for (int k = 0; k < NBM; k++) begin
         if (req[(ptr + k) % NBM]) return (ptr + k) % NBM;
      end
      return -1;
   endfunction

   task automatic apply_reset();
      @(negedge abus_clk);
      abus_rst = 1'b1;
      mreq     = '0;
      mabort   = '0;
      sack     = '0;
      repeat (2) @(negedge abus_clk);
      abus_rst = 1'b0;
      pending  = '0;
      rr_ptr   = 0;
   endtask

   task automatic randomize_masters(input bit fixed_addr, input logic [AW-1:0] addr);
      for (int i = 0; i < NBM; i++) begin
         mid[i*3 +: 3]     = 3'($urandom);
         mwrite[i]         = 1'($urandom);
         mread[i]          = 1'($urandom);
         mstrb[i*SW +: SW] = SW'($urandom);
         mkeep[i*SW +: SW] = SW'($urandom);
         mwdata[i*DW +: DW] = DW'($urandom);
         maddr[i*AW +: AW] = fixed_addr ? addr : AW'($urandom);
      end
   endtask

   // One full transaction from an IDLE cycle: arbitration, BUSY, the chosen ending, back to IDLE.
   task automatic do_txn(input logic [NBM-1:0] add_req, input int kind, input int delay,
                         input bit fixed_addr, input logic [AW-1:0] addr, output int w_obs);
      int             w;
      int             s;
      bit             done;
      logic [NBM-1:0] w_oh;
      logic [NBS-1:0] sel_exp;
      logic [DW-1:0]  rdata_exp;
      pending = pending | add_req;
      mreq    = pending;
      randomize_masters(fixed_addr, addr);
      w = model_winner(pending, rr_ptr);
      if (w < 0) w = 0;
      w_oh    = NBM'(1) << w;
      s       = int'(maddr[w*AW + AW - 1]);
      sel_exp = NBS'(1) << s;
      @(negedge abus_clk);
      #1;
      w_obs = -1;
      for (int i = NBM - 1; i >= 0; i--) if (mgrant[i]) w_obs = i;
      total_cnt++;
      if (mgrant !== w_oh) $display("[TB] FAIL grant: got %b expected %b", mgrant, w_oh);
      else pass_cnt++;
      total_cnt++;
      if ({sreq, smid, saddr, swdata, swrite, sread, sstrb, skeep} !==
          {1'b1, mid[w*3 +: 3], maddr[w*AW +: AW], mwdata[w*DW +: DW], mwrite[w], mread[w],
           mstrb[w*SW +: SW], mkeep[w*SW +: SW]})
         $display("[TB] FAIL slave_cmd: got req=%b addr=%h expected req=1 addr=%h", sreq, saddr, maddr[w*AW +: AW]);
      else pass_cnt++;
      done = 1'b0;
      for (int c = 0; c <= TO && !done; c++) begin
         if (c > 0) begin
            @(negedge abus_clk);
            #1;
         end
         if (kind == K_ACK && c == delay) begin
            srdata = $urandom;
            sack   = sel_exp;
            #1;
            rdata_exp = srdata[s*DW +: DW];
            total_cnt++;
            if ({mack, merr, mrdata} !== {w_oh, 1'b0, rdata_exp})
               $display("[TB] FAIL ack: got mack=%b merr=%b rdata=%h expected %b 0 %h", mack, merr, mrdata, w_oh, rdata_exp);
            else pass_cnt++;
            done = 1'b1;
         end else if ((kind == K_ABORT || kind == K_DROP) && c == delay) begin
            if (kind == K_ABORT) mabort[w] = 1'b1;
            else mreq[w] = 1'b0;
            #1;
            total_cnt++;
            if ({sabort, mack} !== {1'b1, {NBM{1'b0}}})
               $display("[TB] FAIL abort: got sabort=%b mack=%b expected 1 %b", sabort, mack, {NBM{1'b0}});
            else pass_cnt++;
            done = 1'b1;
         end else if (kind == K_TIMEOUT && c == TO) begin
            #1;
            total_cnt++;
            if ({mack, merr, sabort, mgrant, ssel} !== {w_oh, 1'b1, 1'b1, w_oh, {NBS{1'b0}}})
               $display("[TB] FAIL timeout_err: got mack=%b merr=%b sabort=%b ssel=%b expected %b 1 1 %b", mack, merr, sabort, ssel, w_oh, {NBS{1'b0}});
            else pass_cnt++;
            done = 1'b1;
         end else begin
            sack = ~sel_exp;
            #1;
            total_cnt++;
            if ({mack, merr, sabort, ssel, mgrant} !== {{NBM{1'b0}}, 1'b0, 1'b0, sel_exp, w_oh})
               $display("[TB] FAIL busy_hold: got mack=%b sabort=%b ssel=%b grant=%b expected 0 0 %b %b", mack, sabort, ssel, mgrant, sel_exp, w_oh);
            else pass_cnt++;
            sack = '0;
         end
      end
      if (!done) begin
         total_cnt++;
         $display("[TB] FAIL txn_end: got no ending within %0d cycles expected kind %0d", TO + 1, kind);
      end
      @(negedge abus_clk);
      #1;
      sack    = '0;
      mabort  = '0;
      pending = pending & ~w_oh;
      mreq    = pending;
      rr_ptr  = (w + 1) % NBM;
      #1;
      total_cnt++;
      if ({mgrant, mack, merr, sreq, ssel} !== '0)
         $display("[TB] FAIL idle_after: got grant=%b mack=%b merr=%b sreq=%b ssel=%b expected all 0", mgrant, mack, merr, sreq, ssel);
      else pass_cnt++;
   endtask

   task automatic test_reset();
      $display("[TB] test_reset");
      apply_reset();
      #1;
      total_cnt++;
      if ({mgrant, mack, merr, sreq, sabort, ssel, mrdata} !== '0)
         $display("[TB] FAIL reset_rr: got grant=%b mack=%b sreq=%b ssel=%b expected 0", mgrant, mack, sreq, ssel);
      else pass_cnt++;
      total_cnt++;
      if ({lf_mgrant, lf_mack, lf_merr, lf_sreq, lf_sabort, lf_ssel} !== '0)
         $display("[TB] FAIL reset_lf: got grant=%b mack=%b expected 0", lf_mgrant, lf_mack);
      else pass_cnt++;
   endtask

   task automatic test_rr_alternate();
      int w;
      int exp_w [3] = '{0, 1, 0};
      logic [NBM-1:0] adds [3] = '{3'b011, 3'b001, 3'b010};
      $display("[TB] test_rr_alternate");
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         do_txn(adds[i], K_ACK, 2, 1'b0, '0, w);
         total_cnt++;
         if (w !== exp_w[i]) $display("[TB] FAIL rr_order: got M%0d expected M%0d", w, exp_w[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_slave_decode();
      int w;
      $display("[TB] test_slave_decode");
      apply_reset();
      do_txn(3'b010, K_ACK, 1, 1'b1, 16'h8000, w);
      total_cnt++;
      if (w !== 1) $display("[TB] FAIL decode_winner: got M%0d expected M1", w);
      else pass_cnt++;
   endtask

   task automatic test_timeout();
      int w;
      $display("[TB] test_timeout");
      apply_reset();
      do_txn(3'b100, K_TIMEOUT, 0, 1'b0, '0, w);
      total_cnt++;
      if (w !== 2) $display("[TB] FAIL timeout_winner: got M%0d expected M2", w);
      else pass_cnt++;
      do_txn(3'b001, K_ACK, TO - 1, 1'b0, '0, w);
      total_cnt++;
      if (w !== 0) $display("[TB] FAIL late_ack_winner: got M%0d expected M0", w);
      else pass_cnt++;
   endtask

   task automatic test_abort();
      int w;
      $display("[TB] test_abort");
      apply_reset();
      do_txn(3'b011, K_ABORT, 2, 1'b0, '0, w);
      total_cnt++;
      if (w !== 0) $display("[TB] FAIL abort_winner: got M%0d expected M0", w);
      else pass_cnt++;
      do_txn(3'b000, K_ACK, 0, 1'b0, '0, w);
      total_cnt++;
      if (w !== 1) $display("[TB] FAIL after_abort: got M%0d expected M1", w);
      else pass_cnt++;
      do_txn(3'b001, K_DROP, 1, 1'b0, '0, w);
      total_cnt++;
      if (w !== 0) $display("[TB] FAIL drop_winner: got M%0d expected M0", w);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int w;
      int exp_w [4] = '{0, 0, 2, 0};
      logic [NBM-1:0] adds [4] = '{3'b001, 3'b001, 3'b101, 3'b000};
      $display("[TB] test_back_to_back");
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         do_txn(adds[i], K_ACK, 0, 1'b0, '0, w);
         total_cnt++;
         if (w !== exp_w[i]) $display("[TB] FAIL b2b_order: got M%0d expected M%0d", w, exp_w[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_lowest_first();
      $display("[TB] test_lowest_first");
      apply_reset();
      randomize_masters(1'b0, '0);
      mreq = 3'b101;
      for (int i = 0; i < 4; i++) begin
         @(negedge abus_clk);
         #1;
         total_cnt++;
         if (lf_mgrant !== 3'b001) $display("[TB] FAIL lf_grant: got %b expected 001", lf_mgrant);
         else pass_cnt++;
         sack = '1;
         #1;
         total_cnt++;
         if (lf_mack !== 3'b001) $display("[TB] FAIL lf_mack: got %b expected 001", lf_mack);
         else pass_cnt++;
         @(negedge abus_clk);
         #1;
         sack = '0;
         total_cnt++;
         if (lf_mgrant !== 3'b000) $display("[TB] FAIL lf_idle: got %b expected 000", lf_mgrant);
         else pass_cnt++;
      end
      mreq = '0;
   endtask

   task automatic test_reset_mid_busy();
      int w;
      $display("[TB] test_reset_mid_busy");
      apply_reset();
      do_txn(3'b010, K_ACK, 0, 1'b0, '0, w);
      mreq = 3'b100;
      @(negedge abus_clk);
      #1;
      total_cnt++;
      if (mgrant !== 3'b100) $display("[TB] FAIL pre_reset_grant: got %b expected 100", mgrant);
      else pass_cnt++;
      abus_rst = 1'b1;
      @(negedge abus_clk);
      #1;
      total_cnt++;
      if ({mgrant, mack, merr, sreq, sabort, ssel, mrdata} !== '0)
         $display("[TB] FAIL mid_reset: got grant=%b mack=%b sreq=%b sabort=%b ssel=%b expected 0", mgrant, mack, sreq, sabort, ssel);
      else pass_cnt++;
      abus_rst = 1'b0;
      mreq     = '0;
      pending  = '0;
      rr_ptr   = 0;
      do_txn(3'b110, K_ACK, 0, 1'b0, '0, w);
      total_cnt++;
      if (w !== 1) $display("[TB] FAIL ptr_after_reset: got M%0d expected M1", w);
      else pass_cnt++;
   endtask

   task automatic test_random();
      int w;
      int kind;
      logic [NBM-1:0] add;
      $display("[TB] test_random");
      apply_reset();
      for (int n = 0; n < 40; n++) begin
         add = NBM'($urandom);
         if ((pending | add) == '0) add = NBM'(1) << $urandom_range(0, NBM - 1);
         kind = (n % 5 == 4) ? int'($urandom_range(1, 3)) : K_ACK;
         do_txn(add, kind, int'($urandom_range(0, TO - 1)), 1'b0, '0, w);
      end
   endtask

   initial begin
      abus_rst = 1'b1;
      mid = '0; mreq = '0; mwrite = '0; mread = '0; mabort = '0;
      mstrb = '0; mkeep = '0; mwdata = '0; maddr = '0;
      sack = '0; srdata = '0;
      pending = '0;
      rr_ptr  = 0;
      test_reset();
      test_rr_alternate();
      test_slave_decode();
      test_timeout();
      test_abort();
      test_back_to_back();
      test_lowest_first();
      test_reset_mid_busy();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
